// File: rtl/pe_pkg.sv
// pe_pkg: shared width defaults, accumulator-width helper and window FSM encoding.
// Revision: 1.0
`default_nettype none

package pe_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int WEIGHT_WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    COMMIT = 1'b1
  } win_state_e;

  // Wide enough to hold kernel_len maximal products without wrapping.
  function automatic int acc_width(input int dw, input int ww, input int kl);
    return dw + ww + $clog2(kl + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_result_fifo.sv
// pe_result_fifo: show-ahead result buffer with occupancy count; push and pop may coincide at full.
// Revision: 1.0
`default_nettype none

module pe_result_fifo #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // At full a push is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/pe_collector.sv
// pe_collector: sums KERNEL_LEN PE products per window, buffers results, drives feeder stall.
// Optional requantisation (shift + saturate, sat_hit output) under macro PE_COLL_REQUANT_EN. Revision: 1.0
`default_nettype none

module pe_collector
  import pe_pkg::*;
#(
  parameter  int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter  int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter  int KERNEL_LEN   = 9,
  parameter  int FIFO_DEPTH   = 4,
`ifdef PE_COLL_REQUANT_EN
  parameter  int SHIFT        = 4,
`endif
  localparam int PROD_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH,
  localparam int ACC_WIDTH    = acc_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_LEN),
  localparam int CNT_WIDTH    = $clog2(KERNEL_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PROD_WIDTH-1:0] pe_output,
  input  logic                  pe_done,
  input  logic                  win_clr,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  pe_stall,
`ifdef PE_COLL_REQUANT_EN
  output logic                  sat_hit,
`endif
  output logic [CNT_WIDTH-1:0]  win_cnt,
  output logic                  overflow
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  win_state_e            state;
  win_state_e            state_nxt;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  commit_q;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  push_data;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  last;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [FCW:0]          occupancy;
  logic                  stall_q;
  logic                  ovf_q;

  assign prod_ext = ACC_WIDTH'(pe_output);
  assign last     = (cnt == CNT_WIDTH'(KERNEL_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ACCUM;
    if (!win_clr && pe_done && last) begin
      state_nxt = COMMIT;
    end
  end

  always_comb begin
    push = (state == COMMIT);
  end

  // acc and cnt are already zero in COMMIT, so a product there opens the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      commit_q <= '0;
    end else if (win_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (pe_done) begin
      if (last) begin
        commit_q <= acc + prod_ext;
        acc      <= '0;
        cnt      <= '0;
      end else begin
        acc <= acc + prod_ext;
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

`ifdef PE_COLL_REQUANT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);

  logic [ACC_WIDTH-1:0] shifted;
  logic                 sat;
  logic                 sat_q;

  assign shifted   = commit_q >> SHIFT;
  assign sat       = (shifted > SAT_MAX);
  assign push_data = sat ? SAT_MAX : shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= push && sat;
    end
  end

  assign sat_hit = sat_q;
`else
  assign push_data = commit_q;
`endif

  assign pop = res_valid && res_ready;

  pe_result_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (res_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign res_valid = !fifo_empty;
  assign occupancy = {1'b0, fifo_count} + {{FCW{1'b0}}, push};

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      stall_q <= (occupancy >= (FCW + 1)'(FIFO_DEPTH - 1));
      if (push && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign pe_stall = stall_q;
  assign overflow = ovf_q;
  assign win_cnt  = cnt;

endmodule

`default_nettype wire

// File: tb/tb_pe_collector.sv
// tb_pe_collector: directed stimulus with a result scoreboard for pe_collector.
// Revision: 1.0
`default_nettype none

module tb_pe_collector;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int KL = 9;
  localparam int FD = 4;
  localparam int PW = DW + WW;
  localparam int AW = acc_width(DW, WW, KL);
  localparam int CW = $clog2(KL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pe_output;
  logic          pe_done;
  logic          win_clr;
  logic [AW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          pe_stall;
  logic [CW-1:0] win_cnt;
  logic          overflow;
`ifdef PE_COLL_REQUANT_EN
  logic          sat_hit;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  logic [AW-1:0] expq[$];

  pe_collector #(
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW),
    .KERNEL_LEN   (KL),
`ifdef PE_COLL_REQUANT_EN
    .SHIFT        (4),
`endif
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pe_output (pe_output),
    .pe_done   (pe_done),
    .win_clr   (win_clr),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .pe_stall  (pe_stall),
`ifdef PE_COLL_REQUANT_EN
    .sat_hit   (sat_hit),
`endif
    .win_cnt   (win_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected pushed value for a given window sum.
  function automatic logic [AW-1:0] xf(input longint s);
`ifdef PE_COLL_REQUANT_EN
    longint sh;
    sh = s >> 4;
    return (sh > 255) ? AW'(255) : AW'(sh);
`else
    return AW'(s);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL result_unexpected: got %0d, expected none", res_data);
      end else begin
        check("result", res_data, expq.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prod(input int v);
    pe_done   = 1'b1;
    pe_output = PW'(v);
    cyc();
    pe_done   = 1'b0;
  endtask

  task automatic window(input int v);
    repeat (KL) prod(v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || res_valid) && n < 200) begin
      cyc();
      n++;
    end
    check("drain_done", (expq.size() == 0 && !res_valid) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pe_output = '0;
    pe_done   = 1'b0;
    win_clr   = 1'b0;
    res_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_res_valid", res_valid, 0);
    check("rst_pe_stall", pe_stall, 0);
    check("rst_win_cnt", win_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_res_data", res_data, 0);

    // Products 1..9 sum to 45; valid appears two edges after the last product.
    res_ready = 1'b1;
    expq.push_back(xf(45));
    for (int i = 1; i <= 9; i++) prod(i);
    check("lat_commit_cycle", res_valid, 0);
    cyc();
    check("lat_valid", res_valid, 1);
    check("lat_data", res_data, xf(45));
    cyc();
    check("single_pulse", res_valid, 0);

    // Back-to-back maximal products.
    expq.push_back(xf(585225));
    expq.push_back(xf(585225));
    for (int i = 0; i < 18; i++) begin
      prod(65025);
      check("win_cnt_seq", win_cnt, (i % 9 == 8) ? 0 : (i % 9) + 1);
    end
    drain();

    // Backpressure: four windows fill the buffer, the fifth is dropped.
    res_ready = 1'b0;
    window(1);
    expq.push_back(xf(9));
    window(2);
    expq.push_back(xf(18));
    check("stall_low_2buf", pe_stall, 0);
    window(3);
    expq.push_back(xf(27));
    cyc();
    check("stall_high_3buf", pe_stall, 1);
    window(4);
    expq.push_back(xf(36));
    cyc();
    check("no_ovf_at_4", overflow, 0);
    window(5);
    cyc();
    cyc();
    check("ovf_set", overflow, 1);
    check("stall_full", pe_stall, 1);
    check("head_oldest", res_data, xf(9));
    res_ready = 1'b1;
    drain();
    cyc();
    check("stall_released", pe_stall, 0);

    // win_clr with a simultaneous product discards the partial window.
    for (int i = 0; i < 4; i++) prod(10);
    check("win_cnt_pre_clr", win_cnt, 4);
    win_clr   = 1'b1;
    pe_done   = 1'b1;
    pe_output = PW'(10);
    cyc();
    win_clr = 1'b0;
    pe_done = 1'b0;
    check("win_cnt_clr", win_cnt, 0);
    expq.push_back(xf(18));
    window(2);
    drain();

    // Reset mid-window with buffered results discards everything.
    check("ovf_sticky", overflow, 1);
    res_ready = 1'b0;
    window(1);
    window(1);
    for (int i = 0; i < 5; i++) prod(1);
    check("win_cnt_mid", win_cnt, 5);
    check("buffered_valid", res_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_res_valid", res_valid, 0);
    check("mrst_win_cnt", win_cnt, 0);
    check("mrst_overflow", overflow, 0);
    res_ready = 1'b1;
    expq.push_back(xf(27));
    window(3);
    drain();

`ifdef PE_COLL_REQUANT_EN
    expq.push_back(AW'(255));
    for (int i = 0; i < 8; i++) prod(555);
    prod(560);
    cyc();
    check("sat_hit_pulse", sat_hit, 1);
    cyc();
    check("sat_hit_clear", sat_hit, 0);
    expq.push_back(AW'(10));
    for (int i = 0; i < 8; i++) prod(18);
    prod(16);
    cyc();
    check("sat_hit_none", sat_hit, 0);
    drain();
`endif

    check("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
